// File: rtl/alu_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl_pkg
// Brief    : Opcodes, instruction field positions and FSM encoding shared by
//            the ALU issue sequencer and its register file.
// Revision : 1.0
// ============================================================================
package alu_issue_ctrl_pkg;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_XOR = 5'b00100;
    localparam logic [4:0] OP_MUL = 5'b00101;
    localparam logic [4:0] OP_DIV = 5'b00111;
    localparam logic [4:0] OP_NOT = 5'b01000;
    localparam logic [4:0] OP_MOD = 5'b01001;
    localparam logic [4:0] OP_LDI = 5'b01010;
    localparam logic [4:0] OP_CEQ = 5'b01100;
    localparam logic [4:0] OP_CNQ = 5'b01101;
    localparam logic [4:0] OP_CGT = 5'b01110;
    localparam logic [4:0] OP_CLT = 5'b01111;
    localparam logic [4:0] OP_CGE = 5'b10000;
    localparam logic [4:0] OP_CLE = 5'b10001;

    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 11;
    localparam int DST_MSB  = 10;
    localparam int DST_LSB  = 8;
    localparam int SRCA_MSB = 7;
    localparam int SRCA_LSB = 5;
    localparam int SRCB_MSB = 4;
    localparam int SRCB_LSB = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IMM  = 2'd1,
        ST_EXEC = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    function automatic logic op_is_legal(input logic [4:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL,
                          OP_DIV, OP_NOT, OP_MOD, OP_LDI, OP_CEQ, OP_CNQ,
                          OP_CGT, OP_CLT, OP_CGE, OP_CLE};
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
// Module   : alu_regfile
// Brief    : 2**REG_AW x DATA_W register file, two operand read ports, one
//            debug read port, one synchronous write port, reset clears all.
// Revision : 1.0
// ============================================================================
module alu_regfile #(
    parameter int REG_AW = 3,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [REG_AW-1:0] i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [REG_AW-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b,
    input  logic [REG_AW-1:0] i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_data
);

    logic [DATA_W-1:0] r_regs [2**REG_AW];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**REG_AW; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a  = r_regs[i_raddr_a];
    assign o_rdata_b  = r_regs[i_raddr_b];
    assign o_dbg_data = r_regs[i_dbg_addr];

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Brief    : Decodes instruction words, reads operands, drives the external
//            ALU for one cycle, writes back and returns a result handshake.
// Revision : 1.0
// ============================================================================
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int REG_AW = 3,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] InInstr,
    input  logic              InValid,
    output logic              InReady,
    output logic [DATA_W-1:0] AluA,
    output logic [DATA_W-1:0] AluB,
    output logic [4:0]        AluCtrl,
    input  logic [DATA_W-1:0] AluResult,
    output logic [DATA_W-1:0] OutResult,
    output logic [REG_AW-1:0] OutDst,
    output logic              OutError,
    output logic              OutValid,
    input  logic              OutReady,
    input  logic [REG_AW-1:0] DbgAddr,
    output logic [DATA_W-1:0] DbgData
);

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [4:0]        r_alu_ctrl;
    logic [REG_AW-1:0] r_dst;
    logic [DATA_W-1:0] r_out_result;
    logic              r_out_error;

    logic [4:0]        w_op;
    logic [REG_AW-1:0] w_dst;
    logic [REG_AW-1:0] w_srca;
    logic [REG_AW-1:0] w_srcb;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic              w_legal;
    logic              w_accept;
    logic              w_exec_err;
    logic              w_we;

    assign w_op    = InInstr[OP_MSB:OP_LSB];
    assign w_dst   = InInstr[DST_MSB:DST_LSB];
    assign w_srca  = InInstr[SRCA_MSB:SRCA_LSB];
    assign w_srcb  = InInstr[SRCB_MSB:SRCB_LSB];
    assign w_legal = op_is_legal(w_op);

    // Ready is masked during reset so nothing is taken while state is undefined
    assign InReady  = !rst && (r_state == ST_IDLE || r_state == ST_IMM);
    assign w_accept = InValid && InReady;
    assign OutValid = (r_state == ST_RESP);

    assign w_exec_err = (r_alu_ctrl == OP_DIV || r_alu_ctrl == OP_MOD) && (r_alu_b == '0);
    assign w_we       = (r_state == ST_EXEC) && !w_exec_err;

    alu_regfile #(
        .REG_AW (REG_AW),
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_we),
        .i_waddr    (r_dst),
        .i_wdata    (AluResult),
        .i_raddr_a  (w_srca),
        .o_rdata_a  (w_rd_a),
        .i_raddr_b  (w_srcb),
        .o_rdata_b  (w_rd_b),
        .i_dbg_addr (DbgAddr),
        .o_dbg_data (DbgData)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!w_legal)            w_state_next = ST_RESP;
                    else if (w_op == OP_LDI) w_state_next = ST_IMM;
                    else                     w_state_next = ST_EXEC;
                end
            end
            ST_IMM:  if (w_accept) w_state_next = ST_EXEC;
            ST_EXEC: w_state_next = ST_RESP;
            ST_RESP: if (OutReady) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_ctrl   <= '0;
            r_dst        <= '0;
            r_out_result <= '0;
            r_out_error  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_dst <= w_dst;
                        if (!w_legal) begin
                            r_out_error  <= 1'b1;
                            r_out_result <= '0;
                        end else if (w_op != OP_LDI) begin
                            r_alu_a    <= w_rd_a;
                            r_alu_b    <= w_rd_b;
                            r_alu_ctrl <= w_op;
                        end
                    end
                end
                ST_IMM: begin
                    if (w_accept) begin
                        r_alu_a    <= '0;
                        r_alu_b    <= InInstr;
                        r_alu_ctrl <= OP_LDI;
                    end
                end
                ST_EXEC: begin
                    r_out_error  <= w_exec_err;
                    r_out_result <= w_exec_err ? '0 : AluResult;
                end
                default: ;
            endcase
        end
    end

    assign AluA      = r_alu_a;
    assign AluB      = r_alu_b;
    assign AluCtrl   = r_alu_ctrl;
    assign OutResult = r_out_result;
    assign OutDst    = r_dst;
    assign OutError  = r_out_error;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Brief    : Self-checking bench for alu_issue_ctrl with a behavioural ALU and
//            a register-array reference model.
// Revision : 1.0
// ============================================================================
module tb_alu_issue_ctrl;

    localparam logic [4:0] T_ADD = 5'd0,  T_SUB = 5'd1,  T_AND = 5'd2,  T_OR  = 5'd3;
    localparam logic [4:0] T_XOR = 5'd4,  T_MUL = 5'd5,  T_DIV = 5'd7,  T_NOT = 5'd8;
    localparam logic [4:0] T_MOD = 5'd9,  T_LDI = 5'd10, T_CEQ = 5'd12, T_CNQ = 5'd13;
    localparam logic [4:0] T_CGT = 5'd14, T_CLT = 5'd15, T_CGE = 5'd16, T_CLE = 5'd17;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] InInstr;
    logic        InValid;
    logic        InReady;
    logic [15:0] AluA, AluB, AluResult, OutResult, DbgData;
    logic [4:0]  AluCtrl;
    logic [2:0]  OutDst, DbgAddr;
    logic        OutError, OutValid, OutReady;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] ref_regs [8];
    logic [4:0]  ref_ctrl;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] imm;
        logic [15:0] exp_res;
        logic        exp_err;
    } vec_t;
    vec_t tbl [11];

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .InInstr   (InInstr),
        .InValid   (InValid),
        .InReady   (InReady),
        .AluA      (AluA),
        .AluB      (AluB),
        .AluCtrl   (AluCtrl),
        .AluResult (AluResult),
        .OutResult (OutResult),
        .OutDst    (OutDst),
        .OutError  (OutError),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .DbgAddr   (DbgAddr),
        .DbgData   (DbgData)
    );

    function automatic logic [15:0] alu_math(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            T_ADD: return a + b;
            T_SUB: return a - b;
            T_AND: return a & b;
            T_OR:  return a | b;
            T_XOR: return a ^ b;
            T_MUL: return 16'(a * b);
            T_DIV: return (b == 0) ? 16'd0 : a / b;
            T_NOT: return ~a;
            T_MOD: return (b == 0) ? 16'd0 : a % b;
            T_LDI: return b;
            T_CEQ: return {15'd0, a == b};
            T_CNQ: return {15'd0, a != b};
            T_CGT: return {15'd0, a >  b};
            T_CLT: return {15'd0, a <  b};
            T_CGE: return {15'd0, a >= b};
            T_CLE: return {15'd0, a <= b};
            default: return 16'd0;
        endcase
    endfunction

    always_comb AluResult = alu_math(AluCtrl, AluA, AluB);

    function automatic logic ref_legal(input logic [4:0] op);
        return op inside {T_ADD, T_SUB, T_AND, T_OR, T_XOR, T_MUL, T_DIV, T_NOT,
                          T_MOD, T_LDI, T_CEQ, T_CNQ, T_CGT, T_CLT, T_CGE, T_CLE};
    endfunction

    function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] d,
                                        input logic [2:0] a, input logic [2:0] b);
        return {op, d, a, b, 2'b00};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Presents one word and returns just after the edge that transfers it.
    task automatic send_word(input logic [15:0] w);
        int t;
        @(negedge clk);
        InInstr = w;
        InValid = 1'b1;
        t = 0;
        while (!InReady && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_wait", {15'd0, InReady}, 16'd1);
        @(posedge clk);
        #1;
        InValid = 1'b0;
    endtask

    task automatic issue(input logic [15:0] w, input logic [15:0] imm, input int hold,
                         output logic [15:0] got_res, output logic got_err);
        logic [4:0]  op;
        logic [2:0]  d, sa, sb;
        logic [15:0] a, b, e_res;
        logic        e_err, legal;
        op = w[15:11]; d = w[10:8]; sa = w[7:5]; sb = w[4:2];
        legal = ref_legal(op);
        e_err = 1'b1;
        e_res = 16'd0;
        if (legal) begin
            a = (op == T_LDI) ? 16'd0 : ref_regs[sa];
            b = (op == T_LDI) ? imm   : ref_regs[sb];
            ref_ctrl = op;
            if (!((op == T_DIV || op == T_MOD) && b == 0)) begin
                e_err = 1'b0;
                e_res = alu_math(op, a, b);
                ref_regs[d] = e_res;
            end
        end
        DbgAddr = d;
        send_word(w);
        if (legal && op == T_LDI) send_word(imm);
        if (legal) begin
            check("valid_during_exec", {15'd0, OutValid}, 16'd0);
            @(posedge clk);
            #1;
        end
        check("out_valid", {15'd0, OutValid}, 16'd1);
        check("out_result", OutResult, e_res);
        check("out_dst", {13'd0, OutDst}, {13'd0, d});
        check("out_error", {15'd0, OutError}, {15'd0, e_err});
        check("dbg_dst", DbgData, ref_regs[d]);
        check("alu_ctrl", {11'd0, AluCtrl}, {11'd0, ref_ctrl});
        check("in_ready_resp", {15'd0, InReady}, 16'd0);
        got_res = OutResult;
        got_err = OutError;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {15'd0, OutValid}, 16'd1);
            check("hold_result", OutResult, e_res);
            check("hold_dst", {13'd0, OutDst}, {13'd0, d});
            check("hold_in_ready", {15'd0, InReady}, 16'd0);
        end
        OutReady = 1'b1;
        @(posedge clk);
        #1;
        OutReady = 1'b0;
        check("valid_after_accept", {15'd0, OutValid}, 16'd0);
        check("ready_after_accept", {15'd0, InReady}, 16'd1);
    endtask

    initial begin
        logic [15:0] r;
        logic        e;
        logic [15:0] w;
        logic [4:0]  op;

        tbl[0]  = '{enc(T_LDI, 1, 0, 0), 16'h0005, 16'h0005, 1'b0};
        tbl[1]  = '{enc(T_LDI, 2, 0, 0), 16'h0003, 16'h0003, 1'b0};
        tbl[2]  = '{enc(T_ADD, 3, 1, 2), 16'h0000, 16'h0008, 1'b0};
        tbl[3]  = '{enc(T_SUB, 4, 1, 2), 16'h0000, 16'h0002, 1'b0};
        tbl[4]  = '{enc(T_MUL, 4, 1, 2), 16'h0000, 16'h000F, 1'b0};
        tbl[5]  = '{enc(T_CGT, 4, 1, 2), 16'h0000, 16'h0001, 1'b0};
        tbl[6]  = '{enc(T_CLE, 4, 1, 2), 16'h0000, 16'h0000, 1'b0};
        tbl[7]  = '{enc(T_DIV, 5, 1, 0), 16'h0000, 16'h0000, 1'b1};
        tbl[8]  = '{enc(T_MOD, 5, 1, 2), 16'h0000, 16'h0002, 1'b0};
        tbl[9]  = '{enc(5'b00110, 6, 1, 2), 16'h0000, 16'h0000, 1'b1};
        tbl[10] = '{enc(5'b11111, 7, 1, 2), 16'h0000, 16'h0000, 1'b1};

        rst = 1'b1; InInstr = '0; InValid = 1'b0; OutReady = 1'b0; DbgAddr = '0;
        for (int i = 0; i < 8; i++) ref_regs[i] = 16'd0;
        ref_ctrl = 5'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {15'd0, InReady}, 16'd0);
        check("rst_out_valid", {15'd0, OutValid}, 16'd0);
        check("rst_alu_a", AluA, 16'd0);
        check("rst_alu_b", AluB, 16'd0);
        check("rst_alu_ctrl", {11'd0, AluCtrl}, 16'd0);
        check("rst_out_result", OutResult, 16'd0);
        check("rst_out_dst", {13'd0, OutDst}, 16'd0);
        check("rst_out_error", {15'd0, OutError}, 16'd0);
        for (int i = 0; i < 8; i++) begin
            DbgAddr = 3'(i);
            #1;
            check("rst_reg", DbgData, 16'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_release", {15'd0, InReady}, 16'd1);

        // Directed program from a freshly reset register file
        for (int k = 0; k < 11; k++) begin
            issue(tbl[k].instr, tbl[k].imm, 0, r, e);
            check("tbl_result", r, tbl[k].exp_res);
            check("tbl_error", {15'd0, e}, {15'd0, tbl[k].exp_err});
        end

        // Response held off for five cycles before being taken
        issue(enc(T_XOR, 6, 1, 2), 16'h0000, 5, r, e);
        check("hold_xor", r, 16'h0006);

        // Reset landing while waiting for an LDI immediate
        send_word(enc(T_LDI, 6, 0, 0));
        check("imm_wait_ready", {15'd0, InReady}, 16'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_in_ready", {15'd0, InReady}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_release_ready", {15'd0, InReady}, 16'd1);
        check("mid_rst_alu_ctrl", {11'd0, AluCtrl}, 16'd0);
        for (int i = 0; i < 8; i++) begin
            DbgAddr = 3'(i);
            #1;
            check("mid_rst_reg", DbgData, 16'd0);
            ref_regs[i] = 16'd0;
        end
        ref_ctrl = 5'd0;
        issue(enc(T_ADD, 7, 1, 2), 16'h0000, 0, r, e);
        check("fresh_after_rst", r, 16'h0000);

        // Randomised traffic against the reference model
        for (int k = 0; k < 300; k++) begin
            op = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) op = T_LDI;
            w = {op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            issue(w, 16'($urandom), $urandom_range(0, 2), r, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
